// File: rtl/dmem_if.sv
// +--------------------------------------------------------------------+
// | dmem_if : load/store request and response bus for data_mem_unit     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        w_en;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rsp_valid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req_valid, w_en, funct3, addr, wdata,
      input  req_ready, rsp_valid, rdata, err
   );

   modport slave (
      input  req_valid, w_en, funct3, addr, wdata,
      output req_ready, rsp_valid, rdata, err
   );
endinterface

`default_nettype wire

// File: rtl/data_mem_unit.sv
// +--------------------------------------------------------------------+
// | data_mem_unit : word-organised data memory with B/H/W load/store    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module data_mem_unit #(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = 8
) (
   input  logic   clk,
   input  logic   rst_n,
   dmem_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD_RD = 2'd1,
      RESP    = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               req_ready_q, req_ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               err_q, err_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [2:0]         f3_q, f3_d;
   logic [1:0]         off_q, off_d;
   logic [IDX_W-1:0]   idx_q, idx_d;

   logic [31:0]        mem [DEPTH_WORDS];

   logic               accept;
   logic [IDX_W-1:0]   req_idx;
   logic [1:0]         req_off;
   logic               illegal;
   logic               misaligned;
   logic               bad;
   logic               store_en;
   logic [3:0]         be;
   logic [31:0]        wr_data;
   logic [31:0]        rd_word;
   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;
   logic [31:0]        load_ext;
   logic               unused_addr_bits;

   assign accept           = bus.req_valid & req_ready_q;
   assign req_idx          = bus.addr[IDX_W+1:2];
   assign req_off          = bus.addr[1:0];
   assign unused_addr_bits = ^bus.addr[31:IDX_W+2];
   assign bad              = illegal | misaligned;
   assign store_en         = accept & bus.w_en & ~bad;

   always_comb begin
      illegal    = 1'b0;
      misaligned = 1'b0;
      if (bus.w_en) begin
         illegal = bus.funct3[2] | (bus.funct3 == 3'b011);
      end else begin
         illegal = (bus.funct3 == 3'b011) | (bus.funct3[2:1] == 2'b11);
      end
      if ((bus.funct3[1:0] == 2'b01) && req_off[0]) begin
         misaligned = 1'b1;
      end
      if ((bus.funct3 == 3'b010) && (req_off != 2'b00)) begin
         misaligned = 1'b1;
      end
   end

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      be      = 4'b1111;
      wr_data = bus.wdata;
      case (bus.funct3[1:0])
         2'b00: begin
            be      = 4'b0001 << req_off;
            wr_data = {4{bus.wdata[7:0]}};
         end
         2'b01: begin
            be      = req_off[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{bus.wdata[15:0]}};
         end
         default: begin
            be      = 4'b1111;
            wr_data = bus.wdata;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (store_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[req_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      rd_word  = mem[idx_q];
      byte_sel = rd_word[8*off_q +: 8];
      half_sel = rd_word[16*off_q[1] +: 16];
      case (f3_q)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_ext = {24'd0, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_ext = {16'd0, half_sel};
         default: load_ext = rd_word;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      req_ready_d = 1'b0;
      rsp_valid_d = 1'b0;
      err_d       = 1'b0;
      rdata_d     = 32'd0;
      f3_d        = f3_q;
      off_d       = off_q;
      idx_d       = idx_q;
      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (accept) begin
               f3_d        = bus.funct3;
               off_d       = req_off;
               idx_d       = req_idx;
               req_ready_d = 1'b0;
               if (!bus.w_en && !bad) begin
                  state_d = LOAD_RD;
               end else begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  err_d       = bad;
               end
            end
         end
         LOAD_RD: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rdata_d     = load_ext;
         end
         RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= 32'd0;
         f3_q        <= 3'd0;
         off_q       <= 2'd0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         idx_q       <= idx_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.err       = err_q;
   assign bus.rdata     = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_unit.sv
// +--------------------------------------------------------------------+
// | tb_data_mem_unit : randomized bench against a byte-array memory model|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_data_mem_unit;
   localparam int DEPTH = 256;
   localparam int BYTES = DEPTH * 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dmem_if bus ();

   data_mem_unit #(.DEPTH_WORDS(DEPTH), .IDX_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mbytes [BYTES];

   function automatic bit model_reject(input logic we, input logic [2:0] f3, input logic [31:0] a);
      bit legal;
      int size;
      if (we) legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
      else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      if (!legal) return 1'b1;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      return (a % size) != 0;
   endfunction

   function automatic void model_exec(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] wd, output logic e, output logic [31:0] rd);
      int unsigned base;
      int size;
      logic [31:0] v;
      base = a % BYTES;
      e = 1'b0;
      rd = 32'd0;
      v = 32'd0;
      if (model_reject(we, f3, a)) begin
         e = 1'b1;
         return;
      end
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if (we) begin
         for (int k = 0; k < size; k++) mbytes[base + k] = wd[8*k +: 8];
      end else begin
         for (int k = 0; k < size; k++) v[8*k +: 8] = mbytes[base + k];
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
         rd = v;
      end
   endfunction

   task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      bus.req_valid = 1'b1;
      bus.w_en      = we;
      bus.funct3    = f3;
      bus.addr      = a;
      bus.wdata     = wd;
   endtask

   // Issues one request and reports its latency (negedges after the accept edge) and response.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic e, output logic [31:0] rd);
      int w;
      @(negedge clk);
      drive(we, f3, a, wd);
      w = 0;
      while (!bus.req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      lat = -1;
      e   = 1'b0;
      rd  = 32'd0;
      if (!bus.req_ready) begin
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         if (bus.rsp_valid) begin
            lat = k;
            e   = bus.err;
            rd  = bus.rdata;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      bus.req_valid = 1'b0; bus.w_en = 1'b0; bus.funct3 = 3'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.err} !== 3'b000 || bus.rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_async: ready/rsp/err=%b rdata=%h, required 000 and 0",
                  {bus.req_ready, bus.rsp_valid, bus.err}, bus.rdata);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_before_edge: got %b, required 0", bus.req_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_after_edge: ready=%b rsp=%b, required 1 0", bus.req_ready, bus.rsp_valid);
      end
   endtask

   task automatic test_fill();
      int lat; logic e; logic [31:0] rd, wd, ee, er;
      for (int w = 0; w < DEPTH; w++) begin
         wd = $urandom;
         issue(1'b1, 3'b010, 32'(w * 4), wd, lat, e, rd);
         model_exec(1'b1, 3'b010, 32'(w * 4), wd, ee[0], er);
         checks++;
         if (lat !== 1 || e !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL fill_store w=%0d: lat=%0d err=%b rdata=%h, required 1 0 0", w, lat, e, rd);
         end
      end
   endtask

   typedef struct packed {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic        e;
      logic [31:0] rd;
      logic [1:0]  lat;
   } dir_t;

   task automatic test_directed();
      dir_t tbl[$];
      int lat; logic e, me; logic [31:0] rd, mr;
      tbl.push_back(dir_t'{1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        2'd1});
      tbl.push_back(dir_t'{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 2'd2});
      tbl.push_back(dir_t'{1'b1, 3'd0, 32'h11,  32'h80,       1'b0, 32'h0,        2'd1});
      tbl.push_back(dir_t'{1'b0, 3'd0, 32'h11,  32'h0,        1'b0, 32'hFFFFFF80, 2'd2});
      tbl.push_back(dir_t'{1'b0, 3'd4, 32'h11,  32'h0,        1'b0, 32'h00000080, 2'd2});
      tbl.push_back(dir_t'{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'hDEAD80EF, 2'd2});
      tbl.push_back(dir_t'{1'b1, 3'd1, 32'h22,  32'h8001,     1'b0, 32'h0,        2'd1});
      tbl.push_back(dir_t'{1'b0, 3'd1, 32'h22,  32'h0,        1'b0, 32'hFFFF8001, 2'd2});
      tbl.push_back(dir_t'{1'b0, 3'd5, 32'h22,  32'h0,        1'b0, 32'h00008001, 2'd2});
      tbl.push_back(dir_t'{1'b0, 3'd1, 32'h23,  32'h0,        1'b1, 32'h0,        2'd1});
      tbl.push_back(dir_t'{1'b1, 3'd2, 32'h30,  32'hCAFEF00D, 1'b0, 32'h0,        2'd1});
      tbl.push_back(dir_t'{1'b1, 3'd2, 32'h31,  32'h11111111, 1'b1, 32'h0,        2'd1});
      tbl.push_back(dir_t'{1'b0, 3'd2, 32'h30,  32'h0,        1'b0, 32'hCAFEF00D, 2'd2});
      tbl.push_back(dir_t'{1'b1, 3'd4, 32'h30,  32'h22222222, 1'b1, 32'h0,        2'd1});
      tbl.push_back(dir_t'{1'b0, 3'd2, 32'h30,  32'h0,        1'b0, 32'hCAFEF00D, 2'd2});
      tbl.push_back(dir_t'{1'b1, 3'd2, 32'h400, 32'h12345678, 1'b0, 32'h0,        2'd1});
      tbl.push_back(dir_t'{1'b0, 3'd2, 32'h0,   32'h0,        1'b0, 32'h12345678, 2'd2});
      tbl.push_back(dir_t'{1'b0, 3'd2, 32'h2,   32'h0,        1'b1, 32'h0,        2'd1});
      tbl.push_back(dir_t'{1'b0, 3'd3, 32'h0,   32'h0,        1'b1, 32'h0,        2'd1});
      tbl.push_back(dir_t'{1'b1, 3'd0, 32'h403, 32'h777777A5, 1'b0, 32'h0,        2'd1});
      tbl.push_back(dir_t'{1'b0, 3'd2, 32'h0,   32'h0,        1'b0, 32'hA5345678, 2'd2});
      foreach (tbl[i]) begin
         issue(tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, lat, e, rd);
         model_exec(tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, me, mr);
         checks++;
         if (lat !== int'(tbl[i].lat) || e !== tbl[i].e || rd !== tbl[i].rd) begin
            errors++;
            $display("FAIL directed_%0d: lat=%0d err=%b rdata=%h, required lat=%0d err=%b rdata=%h",
                     i, lat, e, rd, tbl[i].lat, tbl[i].e, tbl[i].rd);
         end
      end
   endtask

   task automatic test_random();
      int lat, elat; logic we, e, me; logic [2:0] f3; logic [31:0] a, wd, rd, mr;
      for (int n = 0; n < 300; n++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~((f3[1:0] == 2'd2) ? 32'h3 : (f3[1:0] == 2'd1) ? 32'h1 : 32'h0);
         wd = $urandom;
         elat = (model_reject(we, f3, a) || we) ? 1 : 2;
         issue(we, f3, a, wd, lat, e, rd);
         model_exec(we, f3, a, wd, me, mr);
         checks++;
         if (lat !== elat || e !== me || rd !== mr) begin
            errors++;
            $display("FAIL random_%0d we=%b f3=%0d a=%h: lat=%0d err=%b rdata=%h, required lat=%0d err=%b rdata=%h",
                     n, we, f3, a, lat, e, rd, elat, me, mr);
         end
      end
   endtask

   task automatic test_back_to_back();
      localparam int N = 12;
      logic        we_a [N];
      logic [2:0]  f3_a [N];
      logic [31:0] a_a  [N];
      logic [31:0] wd_a [N];
      logic        ee   [N];
      logic [31:0] er   [N];
      int          acc  [N];
      int          i, nresp, gap;
      bit          need_drive;
      for (int k = 0; k < N; k++) begin
         we_a[k] = 1'($urandom_range(0, 1));
         if (we_a[k]) f3_a[k] = 3'($urandom_range(0, 2));
         else         f3_a[k] = 3'(($urandom_range(0, 4) > 2) ? $urandom_range(4, 5) : $urandom_range(0, 2));
         if (k == 5) f3_a[k] = 3'd3;
         a_a[k] = 32'($urandom_range(0, BYTES - 1));
         if (f3_a[k][1:0] == 2'd1) a_a[k][0]   = 1'b0;
         if (f3_a[k][1:0] == 2'd2) a_a[k][1:0] = 2'b00;
         wd_a[k] = $urandom;
      end
      i = 0; nresp = 0; need_drive = 1'b1;
      for (int t = 0; t < 300 && nresp < N; t++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            checks++;
            if (bus.err !== ee[nresp] || bus.rdata !== er[nresp]) begin
               errors++;
               $display("FAIL b2b_rsp_%0d: err=%b rdata=%h, required err=%b rdata=%h",
                        nresp, bus.err, bus.rdata, ee[nresp], er[nresp]);
            end
            nresp++;
         end
         if (need_drive) begin
            need_drive = 1'b0;
            if (i < N) drive(we_a[i], f3_a[i], a_a[i], wd_a[i]);
            else       bus.req_valid = 1'b0;
         end
         if (bus.req_valid && bus.req_ready) begin
            acc[i] = cyc;
            model_exec(we_a[i], f3_a[i], a_a[i], wd_a[i], ee[i], er[i]);
            i++;
            need_drive = 1'b1;
         end
      end
      bus.req_valid = 1'b0;
      checks++;
      if (nresp != N || i != N) begin
         errors++;
         $display("FAIL b2b_timeout: accepted=%0d responses=%0d, required %0d", i, nresp, N);
      end else begin
         for (int k = 1; k < N; k++) begin
            gap = (!we_a[k-1] && !model_reject(we_a[k-1], f3_a[k-1], a_a[k-1])) ? 3 : 2;
            checks++;
            if (acc[k] - acc[k-1] != gap) begin
               errors++;
               $display("FAIL b2b_spacing_%0d: gap=%0d, required %0d", k, acc[k] - acc[k-1], gap);
            end
         end
      end
   endtask

   task automatic test_reset_midload();
      int lat; logic e, me; logic [31:0] rd, mr;
      @(negedge clk);
      drive(1'b0, 3'd2, 32'h40, 32'h0);
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL midload_ready: got %b, required 1", bus.req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.err} !== 3'b000 || bus.rdata !== 32'd0) begin
         errors++;
         $display("FAIL midload_async: ready/rsp/err=%b rdata=%h, required 000 and 0",
                  {bus.req_ready, bus.rsp_valid, bus.err}, bus.rdata);
      end
      drive(1'b1, 3'd2, 32'h40, 32'hBAD0BAD0);
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midload_no_rsp: rsp_valid=%b, required 0", bus.rsp_valid);
         end
      end
      bus.req_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL midload_release: ready=%b rsp=%b, required 1 0", bus.req_ready, bus.rsp_valid);
      end
      issue(1'b0, 3'd2, 32'h40, 32'h0, lat, e, rd);
      model_exec(1'b0, 3'd2, 32'h40, 32'h0, me, mr);
      checks++;
      if (lat !== 2 || e !== me || rd !== mr) begin
         errors++;
         $display("FAIL midload_storage: lat=%0d err=%b rdata=%h, required lat=2 err=%b rdata=%h",
                  lat, e, rd, me, mr);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fill();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midload();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words in storage; power of two, 4..4096.
REQ-002 Parameter IDX_W, default 8, word-index width, equal to log2(DEPTH_WORDS).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  core presents a load/store request.
REQ-006 req_ready  out  1  unit can accept a request this cycle.
REQ-007 w_en  in  1  0 = load, 1 = store; same meaning as the core's dmem write enable.
REQ-008 funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 addr  in  32  byte address.
REQ-010 wdata  in  32  store data; only the low byte or halfword is used for B/H stores.
REQ-011 rsp_valid  out  1  one-cycle pulse marking completion of the accepted request.
REQ-012 rdata  out  32  load result; valid only while rsp_valid=1.
REQ-013 err  out  1  qualifies rsp_valid; 1 means the request was rejected.

Function
REQ-014 A request is accepted on a rising edge where req_valid=1 and req_ready=1; the unit samples w_en, funct3, addr and wdata on that edge only.
REQ-015 FSM states: IDLE, LOAD_RD, RESP.
REQ-016 req_ready=1 only in IDLE.
REQ-017 IDLE transitions:
  - accepted load goes to LOAD_RD;
  - accepted store or rejected request goes to RESP;
  - no accept stays in IDLE.
REQ-018 LOAD_RD goes to RESP unconditionally. RESP goes to IDLE unconditionally; rsp_valid=1 only in RESP.
REQ-019 Latency, for a request accepted at edge N:
  - store or rejected request: rsp_valid high in the cycle after edge N;
  - load: rsp_valid high in the cycle after edge N+1.
  The next request can be accepted at edge N+2 (store/reject) or N+3 (load).
REQ-020 Word index = addr[IDX_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-021 Misaligned rule:
  - halfword with addr[0]=1 is rejected;
  - word with addr[1:0]!=00 is rejected.
REQ-022 Illegal funct3 is rejected:
  - loads: 011, 110, 111;
  - stores: 011, 100, 101, 110, 111.
REQ-023 A rejected request performs no memory write and no read, and responds with err=1 and rdata=0.
REQ-024 A store writes on the accepting edge N, using byte enables derived from funct3 and addr[1:0]:
  - SB writes wdata[7:0] into byte addr[1:0];
  - SH writes wdata[15:0] into half addr[1];
  - SW writes all 4 bytes.
  Unselected bytes are unchanged. The response has err=0 and rdata=0.
REQ-025 A load reads the addressed word into a register at edge N+1. In RESP, the selected byte/half is right-justified and extended:
  - B and H are sign-extended;
  - BU and HU are zero-extended;
  - W is passed unchanged.
REQ-026 A load that follows a store to the same word returns the post-store data.
REQ-027 req_valid while req_ready=0 is ignored and has no side effect. Requesters hold the request until accepted.
REQ-028 Outside RESP: rsp_valid=0, err=0 and rdata=0.

Reset
REQ-029 While rst_n=0: state=IDLE, req_ready=0, rsp_valid=0, err=0, rdata=0. These take effect immediately, without waiting for a clock edge.
REQ-030 After rst_n deasserts, req_ready=1 from the first rising edge onward.
REQ-031 Reset in LOAD_RD or RESP aborts the request with no response. Reset does not clear storage contents.
REQ-032 An edge with rst_n=0 performs no memory write.

Verification
REQ-033 SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> store rsp one cycle after accept with err=0; load rsp two cycles after accept with rdata=0xDEADBEEF.
REQ-034 After REQ-033:
  - SB addr=0x11 wdata=0x80;
  - LB 0x11 -> 0xFFFFFF80;
  - LBU 0x11 -> 0x00000080;
  - LW 0x10 -> 0xDEAD80EF.
REQ-035 SH addr=0x22 wdata=0x8001; LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LH 0x23 -> err=1, rdata=0.
REQ-036 SW addr=0x31 -> err=1; a following LW 0x30 returns the prior contents unchanged. SW with funct3=100 -> err=1.
REQ-037 SW addr=0x400 (DEPTH_WORDS=256) wdata=0x12345678; LW addr=0x0 -> 0x12345678 (wrap). Back-to-back req_valid held high: accepts spaced exactly 2 or 3 cycles per REQ-019.
REQ-038 Accept a LW, assert rst_n=0 in LOAD_RD -> rsp_valid stays 0, state is IDLE, req_ready=1 on the first edge after release.
